// File: rtl/core_pkg.sv
// Shared decode definitions: opcode constants, immediate formats and the
// decoded bundle that travels through the decode stage registers.
package core_pkg;

  localparam int XLEN_MAX = 64;
  localparam int PC_MAX   = 64;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // NONE is zero so an all-zero bundle is the reset bundle.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [PC_MAX-1:0]   pc;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_t            imm_fmt;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [INST_WIDTH-1:0]     inst;
  logic [PC_WIDTH-1:0]       in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [PC_WIDTH-1:0]       out_pc;
  logic [6:0]                op;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [XLEN-1:0]           imm;
  imm_fmt_t                  imm_fmt;
  logic                      uses_rs1;
  logic                      uses_rs2;
  logic                      writes_rd;
  logic                      illegal;

  modport master (
    output flush, in_valid, inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, op, funct3, funct7, rd, rs1, rs2,
           imm, imm_fmt, uses_rs1, uses_rs2, writes_rd, illegal
  );

  modport slave (
    input  flush, in_valid, inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, op, funct3, funct7, rd, rs1, rs2,
           imm, imm_fmt, uses_rs1, uses_rs2, writes_rd, illegal
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I/RV64I decoder: raw instruction to decoded bundle
// (pc left zero; the stage fills it in).
module decode_logic
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] inst,
  output decoded_t    dec
);
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  shift_hi;
  logic [31:0] imm32;
  logic        known;
  logic        bad;

  assign op     = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // RV64 shift amounts are 6 bits, so only inst[31:26] qualify the shift.
  assign shift_hi = (XLEN == 64) ? {inst[31:26], 1'b0} : inst[31:25];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    dec          = '0;
    dec.op       = op;
    dec.funct3   = funct3;
    dec.funct7   = funct7;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.uses_rs1 = 1'b1;
    dec.writes_rd = 1'b1;
    imm32        = '0;
    known        = 1'b1;
    bad          = 1'b0;

    case (op)
      OP_LUI, OP_AUIPC: begin
        dec.imm_fmt  = IMM_U;
        imm32        = {inst[31:12], 12'b0};
        dec.uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec.imm_fmt  = IMM_J;
        imm32        = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec.uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec.imm_fmt = IMM_I;
        imm32       = {{20{inst[31]}}, inst[31:20]};
        bad         = (funct3 != 3'b000);
      end
      OP_LOAD: begin
        dec.imm_fmt = IMM_I;
        imm32       = {{20{inst[31]}}, inst[31:20]};
        bad         = (funct3 == 3'b111) ||
                      ((XLEN == 32) && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OP_IMM: begin
        dec.imm_fmt = IMM_I;
        imm32       = {{20{inst[31]}}, inst[31:20]};
        if (funct3 == 3'b001)
          bad = (shift_hi != 7'b0000000);
        else if (funct3 == 3'b101)
          bad = (shift_hi != 7'b0000000) && (shift_hi != 7'b0100000);
      end
      OP_SYSTEM: begin
        dec.imm_fmt = IMM_I;
        imm32       = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec.imm_fmt   = IMM_S;
        imm32         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b0;
        bad           = (XLEN == 64) ? (funct3 > 3'b011) : (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        dec.imm_fmt   = IMM_B;
        imm32         = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b0;
        bad           = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_OP: begin
        dec.uses_rs2 = 1'b1;
        bad = !((funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_MISC_MEM: dec.writes_rd = 1'b0;
      default:     known = 1'b0;
    endcase

    dec.imm     = {{(XLEN_MAX-32){imm32[31]}}, imm32};
    dec.illegal = bad || !known;
    if (dec.rd == 5'd0)
      dec.writes_rd = 1'b0;
    if (dec.illegal) begin
      dec.uses_rs1  = 1'b0;
      dec.uses_rs2  = 1'b0;
      dec.writes_rd = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder on the input side feeding a two-entry
// elastic buffer (output register + skid register) with synchronous flush.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  logic [INST_WIDTH-1:0] inst_w;
  decoded_t              dec_raw;
  decoded_t              dec_in;
  decoded_t              out_q;
  decoded_t              skid_q;
  logic                  out_valid;
  logic                  skid_valid;
  logic                  accept;
  logic                  out_free;
  logic                  unused_hi;

  assign inst_w = bus.inst;

  decode_logic #(.XLEN(XLEN)) u_decode_logic (
    .inst (inst_w),
    .dec  (dec_raw)
  );

  always_comb begin
    dec_in    = dec_raw;
    dec_in.pc = 64'(bus.in_pc);
  end

  // A flush-cycle input is dropped even though in_ready may be high.
  assign accept   = bus.in_valid && !skid_valid && !bus.flush;
  assign out_free = !out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept)
          out_q <= dec_in;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid data has no reset; skid_valid qualifies it and is reset.
  always_ff @(posedge clk) begin
    if (accept && !out_free)
      skid_q <= dec_in;
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_q.pc[PC_WIDTH-1:0];
  assign bus.op        = out_q.op;
  assign bus.funct3    = out_q.funct3;
  assign bus.funct7    = out_q.funct7;
  assign bus.rd        = REG_ADDR_WIDTH'(out_q.rd);
  assign bus.rs1       = REG_ADDR_WIDTH'(out_q.rs1);
  assign bus.rs2       = REG_ADDR_WIDTH'(out_q.rs2);
  assign bus.imm       = out_q.imm[XLEN-1:0];
  assign bus.imm_fmt   = out_q.imm_fmt;
  assign bus.uses_rs1  = out_q.uses_rs1;
  assign bus.uses_rs2  = out_q.uses_rs2;
  assign bus.writes_rd = out_q.writes_rd;
  assign bus.illegal   = out_q.illegal;

  // Bundle fields are sized for the widest build; narrower builds drop the top.
  assign unused_hi = ^{out_q.pc, out_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: XLEN=32 and XLEN=64 instances driven
// in lockstep, checked against a queue-based two-entry buffer model.
module tb_decode_stage;
  import core_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic        us1;
    logic        us2;
    logic        wr;
    logic        ill;
  } exp_t;

  item_t q[$];

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .INST_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) bus ();
  decode_stage_if #(.XLEN(64), .INST_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) bus64 ();

  decode_stage #(.XLEN(32), .INST_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  decode_stage #(.XLEN(64), .INST_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  assign bus64.flush     = bus.flush;
  assign bus64.in_valid  = bus.in_valid;
  assign bus64.inst      = bus.inst;
  assign bus64.in_pc     = bus.in_pc;
  assign bus64.out_ready = bus.out_ready;

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference decode from the ISA field definitions, using plain arithmetic.
  function automatic exp_t model(logic [31:0] i, int xlen);
    exp_t   e;
    longint s;
    longint v;
    longint upper;
    logic [2:0] f3;
    logic [6:0] f7;
    s  = longint'($signed(i));
    f3 = i[14:12];
    f7 = i[31:25];
    v  = 0;
    e.fmt = IMM_NONE;
    e.ill = 1'b0;
    e.us1 = 1'b1;
    e.us2 = 1'b0;
    e.wr  = 1'b1;
    case (i[6:0])
      7'h37, 7'h17: begin e.fmt = IMM_U; v = (s >>> 12) * 4096; e.us1 = 1'b0; end
      7'h6F: begin
        e.fmt = IMM_J;
        e.us1 = 1'b0;
        v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096
            + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      7'h67: begin e.fmt = IMM_I; v = s >>> 20; e.ill = (f3 != 0); end
      7'h03: begin
        e.fmt = IMM_I; v = s >>> 20;
        e.ill = (xlen == 32) ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 == 7);
      end
      7'h13: begin
        e.fmt = IMM_I; v = s >>> 20;
        upper = longint'(i >> ((xlen == 64) ? 26 : 25));
        if (f3 == 1) e.ill = (upper != 0);
        if (f3 == 5) e.ill = !(upper == 0 || upper == ((xlen == 64) ? 16 : 32));
      end
      7'h73: begin e.fmt = IMM_I; v = s >>> 20; end
      7'h23: begin
        e.fmt = IMM_S; v = (s >>> 25) * 32 + longint'(i[11:7]);
        e.us2 = 1'b1; e.wr = 1'b0;
        e.ill = (xlen == 64) ? (f3 > 3) : (f3 > 2);
      end
      7'h63: begin
        e.fmt = IMM_B; e.us2 = 1'b1; e.wr = 1'b0;
        v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048
            + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        e.ill = (f3 == 2 || f3 == 3);
      end
      7'h33: begin
        e.us2 = 1'b1;
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h0F: e.wr = 1'b0;
      default: e.ill = 1'b1;
    endcase
    if (i[11:7] == 0) e.wr = 1'b0;
    if (e.ill) begin e.us1 = 1'b0; e.us2 = 1'b0; e.wr = 1'b0; end
    e.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      r[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic check_outputs();
    exp_t e;
    exp_t e64;
    check("out_valid", bus.out_valid, q.size() > 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    check("out_valid64", bus64.out_valid, q.size() > 0);
    check("in_ready64", bus64.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      e   = model(q[0].inst, 32);
      e64 = model(q[0].inst, 64);
      check("out_pc", bus.out_pc, q[0].pc);
      check("op", bus.op, q[0].inst[6:0]);
      check("funct3", bus.funct3, q[0].inst[14:12]);
      check("funct7", bus.funct7, q[0].inst[31:25]);
      check("rd", bus.rd, q[0].inst[11:7]);
      check("rs1", bus.rs1, q[0].inst[19:15]);
      check("rs2", bus.rs2, q[0].inst[24:20]);
      check("imm", bus.imm, e.imm);
      check("imm_fmt", bus.imm_fmt, e.fmt);
      check("uses_rs1", bus.uses_rs1, e.us1);
      check("uses_rs2", bus.uses_rs2, e.us2);
      check("writes_rd", bus.writes_rd, e.wr);
      check("illegal", bus.illegal, e.ill);
      check("out_pc64", bus64.out_pc, q[0].pc);
      check("imm64", bus64.imm, e64.imm);
      check("imm_fmt64", bus64.imm_fmt, e64.fmt);
      check("uses_rs1_64", bus64.uses_rs1, e64.us1);
      check("uses_rs2_64", bus64.uses_rs2, e64.us2);
      check("writes_rd64", bus64.writes_rd, e64.wr);
      check("illegal64", bus64.illegal, e64.ill);
    end
  endtask

  // One cycle: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic step(bit iv, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl);
    bit          acc;
    bit          drn;
    bit          stall;
    logic [31:0] pc_before;
    logic [31:0] imm_before;
    bus.in_valid  = iv;
    bus.inst      = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc   = iv && (q.size() < 2) && !fl;
    drn   = (q.size() > 0) && ordy;
    stall = (q.size() > 0) && !ordy && !fl;
    pc_before  = bus.out_pc;
    imm_before = bus.imm;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clk);
    if (stall) begin
      check("stall out_pc", bus.out_pc, pc_before);
      check("stall imm", bus.imm, imm_before);
    end
    check_outputs();
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.inst = '0;
    bus.in_pc = '0;   bus.out_ready = 1'b0;

    #12;
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset imm", bus.imm, 32'h0);
    check("reset imm_fmt", bus.imm_fmt, IMM_NONE);
    check("reset out_pc", bus.out_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Directed decode cases with hand-derived expectations.
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    check("addi op", bus.op, 7'h13);
    check("addi rd", bus.rd, 5'd1);
    check("addi rs1", bus.rs1, 5'd0);
    check("addi imm", bus.imm, 32'hFFFFFFFF);
    check("addi imm64", bus64.imm, 64'hFFFFFFFF_FFFFFFFF);
    check("addi fmt", bus.imm_fmt, IMM_I);
    check("addi writes_rd", bus.writes_rd, 1'b1);
    check("addi illegal", bus.illegal, 1'b0);

    step(1'b1, 32'hFE000EE3, 32'h104, 1'b1, 1'b0);
    check("beq imm", bus.imm, 32'hFFFFFFFC);
    check("beq fmt", bus.imm_fmt, IMM_B);
    check("beq uses_rs2", bus.uses_rs2, 1'b1);
    check("beq writes_rd", bus.writes_rd, 1'b0);

    step(1'b1, 32'h123452B7, 32'h108, 1'b1, 1'b0);
    check("lui imm", bus.imm, 32'h12345000);
    check("lui fmt", bus.imm_fmt, IMM_U);
    check("lui uses_rs1", bus.uses_rs1, 1'b0);
    check("lui out_valid", bus.out_valid, 1'b1);

    step(1'b1, 32'h00000000, 32'h10C, 1'b1, 1'b0);
    check("zero illegal", bus.illegal, 1'b1);
    check("zero flags", {bus.uses_rs1, bus.uses_rs2, bus.writes_rd}, 3'b000);

    step(1'b1, 32'h00001067, 32'h110, 1'b1, 1'b0);
    check("jalr f3 illegal", bus.illegal, 1'b1);
    check("jalr f3 flags", {bus.uses_rs1, bus.uses_rs2, bus.writes_rd}, 3'b000);

    step(1'b1, 32'h0000B003, 32'h114, 1'b1, 1'b0);
    check("ld illegal rv32", bus.illegal, 1'b1);
    check("ld illegal rv64", bus64.illegal, 1'b0);

    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill output and skid, then flush with a new input presented.
    step(1'b1, 32'h00500113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00A00193, 32'h204, 1'b0, 1'b0);
    check("skid full in_ready", bus.in_ready, 1'b0);
    step(1'b1, 32'h00F00213, 32'h208, 1'b0, 1'b1);
    check("flush out_valid", bus.out_valid, 1'b0);
    check("flush in_ready", bus.in_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flushed input dropped", bus.out_valid, 1'b0);

    // Random stream with random back-pressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int n = 0; n < 3; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 32'h00700293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00800313, 32'h304, 1'b0, 1'b0);
    check("pre-reset in_ready", bus.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", bus.out_valid, 1'b0);
    check("async reset in_ready", bus.in_ready, 1'b1);
    check("async reset imm", bus.imm, 32'h0);
    check("async reset op", bus.op, 7'h0);
    check("async reset rd", bus.rd, 5'd0);
    check("async reset fmt", bus.imm_fmt, IMM_NONE);
    check("async reset out_valid64", bus64.out_valid, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 32'h400, 1'b1, 1'b0);
    check("post-reset imm", bus.imm, 32'hFFFFFFFF);
    check("post-reset out_pc", bus.out_pc, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
